// File: rtl/ddr3_width_bridge.sv
`timescale 1ns/1ps
// Host-to-Avalon width bridge for a DDR3 controller: places narrow host accesses into
// lanes of a wide Avalon word and steers in-order read data back from the recorded lane.
module ddr3_width_bridge #(
  parameter int host_bits  = 32,
  parameter int ratio_bits = 1,
  parameter int addr_bits  = 24,
  parameter int depth_bits = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  output logic                                     ready,
  input  logic [addr_bits+ratio_bits-1:0]          addr,
  input  logic [host_bits-1:0]                     write_data,
  input  logic [host_bits/8-1:0]                   byte_enable,
  input  logic                                     write_req,
  input  logic                                     read_req,
  output logic [host_bits-1:0]                     read_data,
  output logic                                     read_data_valid,
  output logic                                     rdata_underflow,
  input  logic                                     avl_ready,
  output logic                                     avl_burstbegin,
  output logic [addr_bits-1:0]                     avl_addr,
  output logic [(host_bits<<ratio_bits)-1:0]       avl_wdata,
  output logic [(host_bits<<ratio_bits)/8-1:0]     avl_be,
  output logic                                     avl_read_req,
  output logic                                     avl_write_req,
  output logic [6:0]                               avl_size,
  input  logic [(host_bits<<ratio_bits)-1:0]       avl_rdata,
  input  logic                                     avl_rdata_valid
);

  localparam int AVL_W  = host_bits << ratio_bits;
  localparam int AVL_BE = AVL_W / 8;
  localparam int LANE_W = (ratio_bits > 0) ? ratio_bits : 1;
  localparam int CNT_W  = depth_bits + 1;
  localparam logic [CNT_W-1:0] FULL = {1'b1, {depth_bits{1'b0}}};

  logic                  valid_q, valid_d;
  logic                  first_q;
  logic                  is_write_q;
  logic [addr_bits-1:0]  avl_addr_q;
  logic [AVL_W-1:0]      wdata_q;
  logic [AVL_BE-1:0]     be_q;
  logic [depth_bits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [host_bits-1:0]  read_data_q, read_data_d;
  logic                  rdv_q, underflow_q, underflow_d;
  logic [LANE_W-1:0]     lane_mem [2**depth_bits];

  logic                  accept, push, pop, retire;
  logic [LANE_W-1:0]     req_lane, head_lane;
  logic [addr_bits-1:0]  req_word;
  logic [AVL_W-1:0]      wdata_shift;
  logic [AVL_BE-1:0]     be_shift;

  if (ratio_bits > 0) begin : g_lane
    assign req_lane = addr[LANE_W-1:0];
  end else begin : g_no_lane
    assign req_lane = '0;
  end
  assign req_word = addr[addr_bits+ratio_bits-1:ratio_bits];

  // Gated by reset_n so the host sees no acceptance window while the bridge is held in reset.
  assign ready  = reset_n & (~valid_q | avl_ready) & (count_q != FULL);
  assign accept = ready & (read_req | write_req);
  assign push   = accept & read_req & ~write_req;
  assign pop    = avl_rdata_valid & (count_q != '0);
  assign retire = valid_q & avl_ready;

  assign wdata_shift = AVL_W'(write_data) << (req_lane * host_bits);
  assign be_shift    = AVL_BE'(byte_enable) << (req_lane * (host_bits / 8));

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred;
  // clocked blocks use non-blocking '<=' so every register samples pre-edge values.
  always_comb begin
    valid_d = valid_q;
    if (retire) valid_d = 1'b0;
    if (accept) valid_d = 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    wr_ptr_d = wr_ptr_q + depth_bits'(push);
    rd_ptr_d = rd_ptr_q + depth_bits'(pop);

    // An unexpected response with nothing outstanding is steered from lane 0.
    head_lane   = (count_q == '0) ? '0 : lane_mem[rd_ptr_q];
    read_data_d = host_bits'(avl_rdata >> (head_lane * host_bits));
    underflow_d = underflow_q | (avl_rdata_valid & (count_q == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
      rdv_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      first_q     <= accept;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      read_data_q <= avl_rdata_valid ? read_data_d : read_data_q;
      rdv_q       <= avl_rdata_valid;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: payload and lane storage carry no reset; they are only observed behind valid_q or count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_write_q <= write_req;
      avl_addr_q <= req_word;
      wdata_q    <= wdata_shift;
      be_q       <= be_shift;
    end
    if (push) lane_mem[wr_ptr_q] <= req_lane;
  end

  assign avl_burstbegin  = valid_q & first_q;
  assign avl_write_req   = valid_q & is_write_q;
  assign avl_read_req    = valid_q & ~is_write_q;
  assign avl_addr        = avl_addr_q;
  assign avl_wdata       = wdata_q;
  assign avl_be          = be_q;
  assign avl_size        = 7'd1;
  assign read_data       = read_data_q;
  assign read_data_valid = rdv_q;
  assign rdata_underflow = underflow_q;

endmodule

// File: tb/tb_ddr3_width_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for ddr3_width_bridge: a lane/queue model predicts Avalon requests and
// host responses; a negedge monitor compares them as the DUT presents them.
module tb_ddr3_width_bridge;
  localparam int HB = 32;
  localparam int RB = 1;
  localparam int AB = 24;
  localparam int DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              ready;
  logic [AB+RB-1:0]  addr;
  logic [HB-1:0]     write_data;
  logic [HB/8-1:0]   byte_enable;
  logic              write_req, read_req;
  logic [HB-1:0]     read_data;
  logic              read_data_valid, rdata_underflow;
  logic              avl_ready, avl_burstbegin, avl_read_req, avl_write_req, avl_rdata_valid;
  logic [AB-1:0]     avl_addr;
  logic [63:0]       avl_wdata, avl_rdata;
  logic [7:0]        avl_be;
  logic [6:0]        avl_size;

  ddr3_width_bridge #(.host_bits(HB), .ratio_bits(RB), .addr_bits(AB), .depth_bits(DB)) u_dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .addr(addr), .write_data(write_data),
    .byte_enable(byte_enable), .write_req(write_req), .read_req(read_req),
    .read_data(read_data), .read_data_valid(read_data_valid), .rdata_underflow(rdata_underflow),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_size(avl_size), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid));

  // Second build: 16-bit host into a 64-bit Avalon word.
  logic        b_ready, b_write_req, b_read_req, b_read_data_valid, b_rdata_underflow;
  logic [25:0] b_addr;
  logic [15:0] b_write_data, b_read_data;
  logic [1:0]  b_byte_enable;
  logic        b_avl_ready, b_avl_burstbegin, b_avl_read_req, b_avl_write_req, b_avl_rdata_valid;
  logic [23:0] b_avl_addr;
  logic [63:0] b_avl_wdata, b_avl_rdata;
  logic [7:0]  b_avl_be;
  logic [6:0]  b_avl_size;

  ddr3_width_bridge #(.host_bits(16), .ratio_bits(2), .addr_bits(24), .depth_bits(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .ready(b_ready), .addr(b_addr), .write_data(b_write_data),
    .byte_enable(b_byte_enable), .write_req(b_write_req), .read_req(b_read_req),
    .read_data(b_read_data), .read_data_valid(b_read_data_valid),
    .rdata_underflow(b_rdata_underflow), .avl_ready(b_avl_ready),
    .avl_burstbegin(b_avl_burstbegin), .avl_addr(b_avl_addr), .avl_wdata(b_avl_wdata),
    .avl_be(b_avl_be), .avl_read_req(b_avl_read_req), .avl_write_req(b_avl_write_req),
    .avl_size(b_avl_size), .avl_rdata(b_avl_rdata), .avl_rdata_valid(b_avl_rdata_valid));

  typedef struct {
    bit          wr;
    logic [AB-1:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } avl_t;

  typedef struct {
    logic [31:0] data;
    bit          uf;
  } rsp_t;

  avl_t avl_exp_q[$];
  rsp_t rd_exp_q[$];
  int   lq[$];
  int   retired = 0;
  bit   uf_model = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of one accepted host request: word = addr/2, lane = addr%2, payload moved up by lane.
  task automatic accept_model(input bit wr, input bit rd, input logic [AB+RB-1:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    avl_t e;
    int   lane;
    lane    = int'(a % 2);
    e.wr    = wr;
    e.addr  = AB'(a / 2);
    e.wdata = 64'(d) << (HB * lane);
    e.be    = 8'(be) << (4 * lane);
    avl_exp_q.push_back(e);
    if (rd && !wr) lq.push_back(lane);
  endtask

  task automatic resp_drive(input logic [63:0] data);
    rsp_t r;
    int   lane;
    if (lq.size() > 0) lane = lq.pop_front();
    else begin
      lane     = 0;
      uf_model = 1'b1;
    end
    r.data = 32'(data >> (HB * lane));
    r.uf   = uf_model;
    rd_exp_q.push_back(r);
    avl_rdata       = data;
    avl_rdata_valid = 1'b1;
  endtask

  task automatic send_resp(input logic [63:0] data);
    resp_drive(data);
    @(posedge clk); #1;
    avl_rdata_valid = 1'b0;
  endtask

  task automatic host_req(input bit wr, input bit rd, input logic [AB+RB-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    int waited = 0;
    write_req = wr; read_req = rd; addr = a; write_data = d; byte_enable = be;
    @(negedge clk);
    while (!ready && waited < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    if (ready) accept_model(wr, rd, a, d, be);
    else check("host_accept_timeout", ready, 1);
    @(posedge clk); #1;
    write_req = 1'b0; read_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_avl_read_req", avl_read_req, 0);
    check("rst_avl_write_req", avl_write_req, 0);
    check("rst_burstbegin", avl_burstbegin, 0);
    check("rst_read_data_valid", read_data_valid, 0);
    check("rst_read_data", read_data, 0);
    check("rst_underflow", rdata_underflow, 0);
    lq.delete(); avl_exp_q.delete(); rd_exp_q.delete();
    retired = 0; uf_model = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Monitor: Avalon requests, stall stability, burstbegin placement and host responses.
  initial begin : monitor
    bit          prev_stall = 1'b0;
    bit          prev_wr = 1'b0;
    logic [AB-1:0] prev_addr = '0;
    logic [63:0] prev_wdata = '0;
    logic [7:0]  prev_be = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev_stall = 1'b0;
      else begin
        if (avl_read_req || avl_write_req) begin
          if (prev_stall) begin
            check("stall_burstbegin", avl_burstbegin, 0);
            check("stall_write_req", avl_write_req, prev_wr);
            check("stall_addr", avl_addr, prev_addr);
            check("stall_wdata", avl_wdata, prev_wdata);
            check("stall_be", avl_be, prev_be);
          end else begin
            check("burstbegin", avl_burstbegin, 1);
            if (avl_exp_q.size() == 0) check("avl_unexpected_req", avl_exp_q.size(), 1);
            else begin
              avl_t e;
              e = avl_exp_q.pop_front();
              check("avl_write_req", avl_write_req, e.wr);
              check("avl_addr", avl_addr, e.addr);
              if (e.wr) begin
                check("avl_wdata", avl_wdata, e.wdata);
                check("avl_be", avl_be, e.be);
              end
            end
          end
          check("avl_size", avl_size, 1);
          if (!avl_ready) check("stall_ready", ready, 0);
          prev_stall = !avl_ready;
          prev_wr = avl_write_req; prev_addr = avl_addr; prev_wdata = avl_wdata; prev_be = avl_be;
          if (avl_read_req && avl_ready) retired++;
        end else begin
          check("idle_burstbegin", avl_burstbegin, 0);
          prev_stall = 1'b0;
        end
        if (read_data_valid) begin
          if (rd_exp_q.size() == 0) check("unexpected_response", rd_exp_q.size(), 1);
          else begin
            rsp_t r;
            r = rd_exp_q.pop_front();
            check("read_data", read_data, r.data);
            check("rdata_underflow", rdata_underflow, r.uf);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    addr = '0; write_data = '0; byte_enable = '0; write_req = 1'b0; read_req = 1'b0;
    avl_ready = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;
    b_addr = '0; b_write_data = '0; b_byte_enable = '0; b_write_req = 1'b0; b_read_req = 1'b0;
    b_avl_ready = 1'b0; b_avl_rdata = '0; b_avl_rdata_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single write to the upper lane.
    avl_ready = 1'b1;
    host_req(1'b1, 1'b0, 25'h3, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("wr_avl_addr", avl_addr, 24'h1);
    check("wr_avl_wdata", avl_wdata, 64'hDEADBEEF_00000000);
    check("wr_avl_be", avl_be, 8'hF0);
    check("wr_burstbegin", avl_burstbegin, 1);
    @(negedge clk);
    check("wr_burstbegin_single", avl_burstbegin, 0);
    @(posedge clk); #1;

    // Read held off by avl_ready=0 for three cycles.
    avl_ready = 1'b0;
    host_req(1'b0, 1'b1, 25'h5, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_read_req", avl_read_req, 1);
      check("stall_bb", avl_burstbegin, (i == 0));
      check("stall_host_ready", ready, 0);
      @(posedge clk); #1;
    end
    avl_ready = 1'b1;
    @(posedge clk); #1;
    send_resp(64'h11112222_33334444);
    @(negedge clk);
    check("rd_valid", read_data_valid, 1);
    check("rd_data_upper", read_data, 32'h11112222);
    @(posedge clk); #1;

    // Fill all 16 outstanding slots; the 17th request must wait for a pop.
    for (int i = 0; i < 16; i++) host_req(1'b0, 1'b1, 25'($urandom()), 32'h0, 4'h0);
    @(negedge clk);
    check("full_ready", ready, 0);
    @(posedge clk); #1;
    write_req = 1'b1; addr = 25'h40; write_data = 32'hCAFEF00D; byte_enable = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_blocks_write", ready, 0);
      @(posedge clk); #1;
    end
    resp_drive(64'($urandom()) << 32 | 64'($urandom()));
    @(negedge clk);
    check("full_same_cycle_pop", ready, 0);
    @(posedge clk); #1;
    avl_rdata_valid = 1'b0;
    host_req(1'b1, 1'b0, 25'h40, 32'hCAFEF00D, 4'h3);
    for (int i = 0; i < 15; i++) send_resp({32'($urandom()), 32'($urandom())});
    repeat (2) @(posedge clk); #1;

    // Lane ordering 1,0,1.
    host_req(1'b0, 1'b1, 25'h21, 32'h0, 4'h0);
    host_req(1'b0, 1'b1, 25'h30, 32'h0, 4'h0);
    host_req(1'b0, 1'b1, 25'h11, 32'h0, 4'h0);
    @(posedge clk); #1;
    send_resp(64'hAAAA0001_AAAA0002);
    send_resp(64'hBBBB0001_BBBB0002);
    send_resp(64'hCCCC0001_CCCC0002);
    repeat (2) @(posedge clk); #1;

    // Response with nothing outstanding.
    send_resp(64'h01234567_89ABCDEF);
    @(negedge clk);
    @(negedge clk);
    check("underflow_sticky", rdata_underflow, 1);
    @(posedge clk); #1;
    do_reset();

    // Randomised traffic.
    begin
      int   issued = 0;
      int   cyc = 0;
      bit   active = 1'b0;
      bit   done_acc = 1'b0;
      logic [AB+RB-1:0] ra;
      logic [31:0] rd_;
      logic [3:0]  rb;
      bit   rw, rr;
      while ((issued < 300 || active || lq.size() > 0) && cyc < 20000) begin
        @(posedge clk); #1;
        cyc++;
        if (done_acc) begin
          write_req = 1'b0; read_req = 1'b0; active = 1'b0; done_acc = 1'b0;
        end
        avl_ready = ($urandom_range(0, 3) != 0);
        if (retired > 0 && $urandom_range(0, 2) == 0) begin
          resp_drive({32'($urandom()), 32'($urandom())});
          retired--;
        end else avl_rdata_valid = 1'b0;
        if (!active && issued < 300 && $urandom_range(0, 1) == 1) begin
          int k = $urandom_range(0, 9);
          rw = (k < 4) || (k == 9);
          rr = (k >= 4);
          ra = 25'($urandom()); rd_ = $urandom(); rb = 4'($urandom());
          write_req = rw; read_req = rr; addr = ra; write_data = rd_; byte_enable = rb;
          active = 1'b1;
          issued++;
        end
        @(negedge clk);
        if (lq.size() == 16) check("rand_full_ready", ready, 0);
        if (active && !done_acc && ready) begin
          accept_model(rw, rr, ra, rd_, rb);
          done_acc = 1'b1;
        end
      end
      if (cyc >= 20000) check("random_phase_timeout", lq.size(), 0);
      @(posedge clk); #1;
      write_req = 1'b0; read_req = 1'b0; avl_rdata_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("avl_queue_drained", avl_exp_q.size(), 0);
      check("rsp_queue_drained", rd_exp_q.size(), 0);
    end

    // 16-bit host build: write to lane 3, read from lane 2.
    @(posedge clk); #1;
    b_avl_ready = 1'b1;
    b_addr = {24'h000ABC, 2'd3}; b_write_data = 16'hABCD; b_byte_enable = 2'b11; b_write_req = 1'b1;
    @(negedge clk);
    check("b_ready", b_ready, 1);
    @(posedge clk); #1;
    b_write_req = 1'b0;
    @(negedge clk);
    check("b_avl_write_req", b_avl_write_req, 1);
    check("b_avl_addr", b_avl_addr, 24'h000ABC);
    check("b_avl_be", b_avl_be, 8'hC0);
    check("b_avl_wdata", b_avl_wdata, 64'hABCD_0000_0000_0000);
    @(posedge clk); #1;
    b_addr = {24'h000012, 2'd2}; b_read_req = 1'b1;
    @(posedge clk); #1;
    b_read_req = 1'b0;
    @(posedge clk); #1;
    b_avl_rdata = 64'h4444_3333_2222_1111; b_avl_rdata_valid = 1'b1;
    @(posedge clk); #1;
    b_avl_rdata_valid = 1'b0;
    @(negedge clk);
    check("b_read_data_valid", b_read_data_valid, 1);
    check("b_read_data_lane2", b_read_data, 16'h3333);
    check("b_underflow", b_rdata_underflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_width_bridge.md
DDR3_WIDTH_BRIDGE -- requirements
Module: ddr3_width_bridge

Interface
REQ-001 Parameter host_bits, default 32: host data width in bits; multiple of 8.
REQ-002 Parameter ratio_bits, default 1: log2(Avalon width / host width); avl width = host_bits << ratio_bits.
REQ-003 Parameter addr_bits, default 24: Avalon word-address width.
REQ-004 Parameter depth_bits, default 4: log2 of the maximum number of outstanding reads.
REQ-005 Port clk, input, 1: the single clock; every register is clocked on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous active-low reset.
REQ-007 Ports ready out 1; addr in addr_bits+ratio_bits (host-word address); write_data in host_bits; byte_enable in host_bits/8; write_req in 1; read_req in 1: host request side.
REQ-008 Ports read_data out host_bits; read_data_valid out 1; rdata_underflow out 1 (sticky error): host response side.
REQ-009 Ports avl_ready in 1; avl_burstbegin out 1; avl_addr out addr_bits; avl_wdata out avl width; avl_be out avl width/8; avl_read_req out 1; avl_write_req out 1; avl_size out 7; avl_rdata in avl width; avl_rdata_valid in 1: Avalon-MM controller side.

Function
REQ-010 A host request is accepted in a cycle where ready=1 and (read_req or write_req) is 1.
REQ-011 If read_req and write_req are both 1, the request is a write only; no lane entry is pushed.
REQ-012 lane = addr[ratio_bits-1:0]; the Avalon word address is addr[addr_bits+ratio_bits-1:ratio_bits].
REQ-013 An accepted request loads a one-entry request register (valid, is_write, avl_addr, wdata, be) and drives the avl_* outputs the next cycle (1-cycle latency).
REQ-014 avl_wdata = write_data shifted left by lane*host_bits, zero elsewhere; avl_be = byte_enable shifted left by lane*host_bits/8, zero elsewhere.
REQ-015 avl_write_req = valid & is_write; avl_read_req = valid & !is_write; avl_size = 1 constant.
REQ-016 avl_burstbegin is 1 only in the first cycle a given request is valid on the Avalon outputs, and stays 0 in later stall cycles of the same request.
REQ-017 The request register retires in a cycle where valid=1 and avl_ready=1; it is empty afterwards unless reloaded in the same cycle (back-to-back, with a new burstbegin).
REQ-018 Avalon outputs hold stable while valid=1 and avl_ready=0.
REQ-019 Lane FIFO: 2**depth_bits entries of ratio_bits bits. Push the lane on each accepted read; pop on avl_rdata_valid.
REQ-020 Outstanding-read count: increments on push, decrements on pop, unchanged on a simultaneous push and pop; range 0..2**depth_bits.
REQ-021 ready = (!valid or avl_ready) and (count < 2**depth_bits); it is combinational and does not depend on read_req/write_req.
REQ-022 When count == 2**depth_bits, ready is 0 for all requests, including writes; a same-cycle pop does not lift ready in that cycle.
REQ-023 The response is registered. The cycle after avl_rdata_valid=1: read_data_valid=1 and read_data = avl_rdata[(lane+1)*host_bits-1 : lane*host_bits], where lane is the FIFO head.
REQ-024 avl_rdata_valid with count == 0: still respond using lane 0, leave the count at 0, and set rdata_underflow=1 until reset.
REQ-025 Responses return strictly in request order; the controller is assumed in-order.

Reset
REQ-026 Asserting reset_n=0 immediately clears: valid, burstbegin flag, FIFO pointers, count, read_data_valid, and rdata_underflow.
REQ-027 During reset, ready, avl_read_req, avl_write_req, avl_burstbegin and read_data_valid are 0; read_data is 0.
REQ-028 Reset mid-operation discards in-flight requests and pending lanes; responses arriving after reset release are handled per REQ-024.

Verification
REQ-029 Defaults; write addr=0x3, data=0xDEADBEEF, be=0xF, avl_ready=1 -> next cycle: avl_addr=0x1, avl_wdata=0xDEADBEEF_00000000, avl_be=0xF0, burstbegin=1 for one cycle.
REQ-030 Read addr=0x5 with avl_ready=0 held for 3 cycles -> avl_read_req held, burstbegin high only in the first cycle, ready=0 during the stall. Then rdata=0x11112222_33334444 -> read_data=0x11112222 one cycle later.
REQ-031 Issue 16 reads with no responses -> ready falls after the 16th. A 17th request (read or write) is not accepted until a response pops.
REQ-032 Reads to lanes 1,0,1 -> responses A,B,C yield upper(A), lower(B), upper(C) in order.
REQ-033 avl_rdata_valid with nothing outstanding -> read_data_valid=1 and rdata_underflow=1 sticky. Then reset -> rdata_underflow=0.
REQ-034 ratio_bits=2, host_bits=16 build: write to lane 3 -> avl_be=0xC0 and data in bits 63:48.
